// File: rtl/ps2_keyboard_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared definitions for the PS/2 keyboard receiver: frame
//               geometry, receive FSM state type and the frame validity check.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } ps2_rx_state_t;

    // Frame layout: [0]=start, [8:1]=data LSB first, [9]=parity, [10]=stop.
    // Valid when start is 0, stop is 1 and data+parity carry odd parity.
    function automatic bit ps2_frame_ok(input logic [PS2_FRAME_BITS-1:0] frame);
        return (frame[0] == 1'b0) &&
               (frame[PS2_FRAME_BITS-1] == 1'b1) &&
               ((^frame[PS2_FRAME_BITS-2:1]) == 1'b1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_keyboard_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_fifo
// Description : Synchronous first-word fall-through FIFO for received scan
//               codes. The head entry is always presented on pop_data; a push
//               into a full FIFO is accepted only when a pop frees a slot in
//               the same cycle, otherwise it is dropped and drop is raised.
// Ports       : clk, rst (async, active-low)
//               push / push_data    - write request and byte
//               pop                 - consume head (ignored when empty)
//               pop_data            - head entry, 0 while empty
//               full / empty        - occupancy status
//               drop                - push rejected this cycle (FIFO full)
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int c_AW = $clog2(DEPTH);
    // DEPTH is a power of two, so "full" is the count MSB alone.
    localparam logic [c_AW:0] c_FULL = {1'b1, {c_AW{1'b0}}};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;

    logic w_pop;
    logic w_push;

    assign full  = (r_count == c_FULL);
    assign empty = (r_count == '0);
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);
    assign drop   = push & full & ~w_pop;

    // Gated so the output reads 0 out of reset rather than stale storage.
    assign pop_data = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_keyboard_rx
// Description : PS/2 keyboard receiver. Synchronises the PS/2 pins, frames
//               11-bit words on PS/2 clock falling edges, validates start,
//               stop and odd parity, and queues good scan codes in a FWFT
//               FIFO drained by a valid/ready handshake.
// Ports       : clk, rst (async, active-low)
//               ps2_clk, ps2_data   - raw PS/2 pins (asynchronous)
//               data / valid / ready - FIFO head handshake
//               frame_err           - 1-cycle pulse on a bad completed frame
//               overflow / ovf_clr  - sticky drop flag and its clear
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam int                c_SHIFT_W  = PS2_FRAME_BITS - 1;
    localparam logic [3:0]        c_LAST_BIT = 4'(PS2_FRAME_BITS - 1);
    localparam int                c_TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_LIMIT = c_TO_W'(TIMEOUT_CYCLES);

    // Synchronisers; reset high so an idle bus never looks like a falling edge.
    logic r_clk_s1, r_clk_s2, r_clk_s3;
    logic r_dat_s1, r_dat_s2;

    ps2_rx_state_t r_state, w_state_nxt;
    logic [3:0]           r_bcnt;
    logic [c_SHIFT_W-1:0] r_shift;
    logic                 r_start;
    logic [c_TO_W-1:0]    r_timer;
    logic                 r_done;
    logic                 r_frame_err;
    logic                 r_overflow;

    logic                      w_fall;
    logic                      w_timeout;
    logic                      w_frame_end;
    logic [PS2_FRAME_BITS-1:0] w_frame;
    logic                      w_good;
    logic                      w_push;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_drop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_s3 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_clk_s3 <= r_clk_s2;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    assign w_fall = r_clk_s3 & ~r_clk_s2;

    // A falling edge on the same cycle as expiry wins, so the bit is not lost.
    assign w_timeout = (r_state == RECV) && !w_fall && (r_timer == c_TO_LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_frame_end = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_nxt = RECV;
                end
            end
            RECV: begin
                if (w_fall) begin
                    if (r_bcnt == c_LAST_BIT) begin
                        w_state_nxt = IDLE;
                        w_frame_end = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Start bit is held apart; the shifter collects data, parity and stop so
    // that after the last shift r_shift[7:0] is the byte, [8] parity, [9] stop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bcnt  <= '0;
            r_shift <= '0;
            r_start <= 1'b0;
            r_timer <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_frame_end;
            if (w_fall) begin
                r_timer <= '0;
                if (r_state == IDLE) begin
                    r_start <= r_dat_s2;
                    r_bcnt  <= 4'd1;
                end else begin
                    r_shift <= {r_dat_s2, r_shift[c_SHIFT_W-1:1]};
                    r_bcnt  <= w_frame_end ? 4'd0 : r_bcnt + 4'd1;
                end
            end else if (r_state == RECV) begin
                if (w_timeout) begin
                    r_timer <= '0;
                    r_bcnt  <= '0;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end else begin
                r_timer <= '0;
            end
        end
    end

    // Checked one cycle after the last shift, from the fully registered frame.
    assign w_frame = {r_shift, r_start};
    assign w_good  = ps2_frame_ok(w_frame);
    assign w_push  = r_done & w_good;

    ps2_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_frame[8:1]),
        .pop       (ready),
        .pop_data  (data),
        .full      (w_full),
        .empty     (w_empty),
        .drop      (w_drop)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_frame_err <= r_done & ~w_good;
            // A new drop outranks a simultaneous clear.
            if (w_drop & w_full) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign valid     = ~w_empty;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Receives PS/2 keyboard frames from the board's `ps2_clk`/`ps2_data` pins, validates them, and queues the scan-code bytes in a small FIFO. It sits directly upstream of the scan-code decode and seven-segment display logic in `top`, which pops one byte per valid/ready handshake. Framing, parity and FIFO-overflow errors are reported to that logic for display on `ledr`.

## Interface
- `FIFO_DEPTH`, default 8: number of FIFO entries; must be a power of two, ≥2.
- `TIMEOUT_CYCLES`, default 10000: `clk` cycles with no PS/2 falling edge before a partial frame is discarded.
- `clk` in 1: system clock.
- `rst` in 1: reset; asynchronous assert, active-low (0 = reset).
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous to `clk`.
- `data` out 8: scan code at the FIFO head; defined only while `valid`=1.
- `valid` out 1: FIFO not empty.
- `ready` in 1: consumer accepts `data` on a cycle where `valid & ready`.
- `frame_err` out 1: one-cycle pulse when a completed frame fails start, stop or parity check.
- `overflow` out 1: sticky; set when a good frame is dropped because the FIFO is full.
- `ovf_clr` in 1: synchronous clear of `overflow`.

## Operation
- Synchronisers:
  - `ps2_clk` passes through 3 flops `s1→s2→s3`.
  - `fall` = `s3 & ~s2`.
  - `ps2_data` passes through 2 flops, aligned with `s2`.
- Receive FSM, states `IDLE` and `RECV`, with a 4-bit bit counter `bcnt` and a 10-bit shift register shifting right, MSB in.
  - `IDLE` + `fall`: capture the start bit, set `bcnt`=1, go to `RECV`.
  - `RECV` + `fall`: shift in the bit and increment `bcnt`.
  - On the 11th bit (`bcnt`=10 at the fall), the frame is checked and the FSM returns to `IDLE`.
- Frame format: start=0, 8 data bits LSB first, odd parity, stop=1.
  - Good frame: start=0, stop=1, and XOR of the 8 data bits and the parity bit = 1.
  - Good frame → push the data byte.
  - Bad frame → assert `frame_err` for 1 cycle and push nothing.
- Timeout: a counter clears on every `fall` and increments in `RECV`.
  - When it reaches `TIMEOUT_CYCLES`, go to `IDLE` and clear `bcnt`. No `frame_err`.
  - The counter is held at 0 in `IDLE`.
- FIFO: first-word fall-through.
  - `data` = mem[rd_ptr], `valid` = count≠0.
  - Pop on `valid & ready`.
- Full FIFO with a push:
  - If a pop happens in the same cycle, the push is accepted and count is unchanged.
  - Otherwise the byte is dropped, `overflow` is set, and FIFO contents are unchanged.
- `overflow` priority: a set in the same cycle as `ovf_clr` wins (flag stays 1).
- Pointers are log2(`FIFO_DEPTH`) bits wide and wrap naturally. Count is log2(`FIFO_DEPTH`)+1 bits wide.

## Timing
- Reset values:
  - all synchroniser flops = 1;
  - FSM = `IDLE`, `bcnt`=0, timeout=0;
  - FIFO empty;
  - `valid`=0, `data`=0, `frame_err`=0, `overflow`=0.
- Reset mid-frame discards the partial frame and FIFO contents. The next falling edge after release is treated as a start bit.
- Latency: let edge N be the first `clk` edge at which `s1` captures 0 for the stop-bit fall.
  - `fall` is high during cycle N+2.
  - The push and the `frame_err` pulse register at edge N+3.
  - `valid` (or `frame_err`) is visible after edge N+3.
- Pop takes effect at the clk edge; the next entry appears on `data` in the following cycle.
- One `fall` is processed per assertion; `fall` lasts exactly 1 cycle.
- Consecutive pushes are ≥11 PS/2 bit times apart, so at most one push occurs per cycle.

## Structure
- Package `ps2_pkg`:
  - `PS2_FRAME_BITS`=11;
  - state enum `ps2_rx_state_t` {`IDLE`,`RECV`};
  - function `ps2_frame_ok`, taking the 11-bit frame and returning bit.
- Sub-module `ps2_fifo`: synchronous FWFT FIFO parameterised by depth and width (8). It provides push/pop/full/empty and a drop indication.
- The top level holds the synchronisers, FSM, timeout counter and flag logic.

## Test plan
- Good frame 0x1C (bits 0,0,0,1,1,1,0,0,0,parity 0,stop 1), then idle with `ready`=0 → `valid`=1, `data`=0x1C exactly 3 cycles after stop-fall sampling. `ready`=1 → `valid`=0 on the next cycle.
- Frame 0x1C with parity bit 1 → a single-cycle `frame_err`, `valid` stays 0. Frame with stop=0 → `frame_err`.
- 9 good frames 0x01..0x09 with `ready`=0, depth 8 → `overflow`=1 after the 9th. Popping yields 0x01..0x08, then `valid`=0. `ovf_clr` → `overflow`=0.
- FIFO full, 9th frame completes on the same cycle as a pop → no overflow; the sequence reads 0x02..0x09.
- 5 bits sent, then idle > `TIMEOUT_CYCLES`, then good frame 0xF0 → only 0xF0 is received, no `frame_err`.
- `rst` asserted after 6 bits and 2 queued bytes, released, then frame 0x5A → `valid`=0 after reset, then only 0x5A is received.
